// File: rtl/demux4_lane_if.sv
// demux4_lane_if: handshake and lane bus for the 1-to-4 demultiplexer.
//   in_data/in_valid/in_ready : input stream (valid/ready)
//   in_sel/auto_mode/sync     : lane selection and round-robin control
//   out_data/out_valid/out_ready : four output lanes, lane k at [k*WIDTH +: WIDTH]
//   cur_sel/frame_done        : status (next target lane, end-of-frame pulse)
// master = producer/consumer side, slave = the demultiplexer.
interface demux4_lane_if #(
    parameter int unsigned WIDTH = 1
);
    localparam int unsigned LANES = 4;

    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_sel;
    logic                   auto_mode;
    logic                   sync;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic [LANES-1:0]       out_ready;
    logic [1:0]             cur_sel;
    logic                   frame_done;

    modport master (
        output in_data, in_valid, in_sel, auto_mode, sync, out_ready,
        input  in_ready, out_data, out_valid, cur_sel, frame_done
    );

    modport slave (
        input  in_data, in_valid, in_sel, auto_mode, sync, out_ready,
        output in_ready, out_data, out_valid, cur_sel, frame_done
    );
endinterface

// File: rtl/demux4_lane.sv
// demux4_lane: registered 1-to-4 demultiplexer with one holding register per lane.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : demux4_lane_if.slave (input stream, lane outputs, selection, status)
// The target lane is in_sel (direct mode) or a round-robin pointer (auto mode).
// in_ready and cur_sel are combinational; lane data/valid and frame_done are registered.
module demux4_lane #(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    demux4_lane_if.slave bus
);
    localparam int unsigned LANES = 4;

    logic [1:0]             r_ptr;
    logic [LANES-1:0]       r_valid;
    logic [LANES*WIDTH-1:0] r_data;
    logic                   r_frame_done;

    logic [1:0]             w_tgt;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_auto_accept;
    logic [LANES-1:0]       w_wr;
    logic [LANES-1:0]       w_valid_nxt;
    logic [1:0]             w_ptr_nxt;

    // Lane selection, handshake and next-state computation
    always_comb begin
        w_tgt         = bus.auto_mode ? r_ptr : bus.in_sel;
        w_ready       = !r_valid[w_tgt] || bus.out_ready[w_tgt];
        // Nothing is stored while reset is held, even if the handshake completes.
        w_accept      = bus.in_valid && w_ready && !rst;
        w_auto_accept = w_accept && bus.auto_mode;
        w_wr          = '0;
        if (w_accept) begin
            w_wr[w_tgt] = 1'b1;
        end
        // A write wins over a drain on the same lane, keeping the lane full.
        for (int k = 0; k < LANES; k++) begin
            w_valid_nxt[k] = w_wr[k] || (r_valid[k] && !bus.out_ready[k]);
        end
        // sync overrides the advance: an accept with sync lands at ptr, then ptr restarts at 1.
        w_ptr_nxt = r_ptr;
        if (w_auto_accept) begin
            w_ptr_nxt = bus.sync ? 2'd1 : 2'(r_ptr + 2'd1);
        end else if (bus.sync) begin
            w_ptr_nxt = 2'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= 2'd0;
            r_valid      <= '0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_valid      <= w_valid_nxt;
            r_frame_done <= w_auto_accept && (r_ptr == 2'd3);
            for (int k = 0; k < LANES; k++) begin
                if (w_wr[k]) begin
                    r_data[k*WIDTH +: WIDTH] <= bus.in_data;
                end
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.cur_sel    = w_tgt;
    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_demux4_lane.sv
// tb_demux4_lane: directed and random stimulus for demux4_lane (WIDTH=4),
// checked each cycle against a lane-array reference model.
module tb_demux4_lane;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux4_lane_if #(.WIDTH(W)) bus ();

    demux4_lane #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: four lanes each either empty or holding a value, plus a pointer.
    bit         m_full [4];
    logic [3:0] m_data [4];
    int         m_ptr;
    bit         m_fd;
    bit         m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input bit v, input logic [3:0] d, input logic [1:0] sel,
                        input bit am, input bit sy, input logic [3:0] ordy, input bit r);
        int         t;
        bit         exp_ready;
        bit         acc;
        logic [3:0] exp_v;
        logic [15:0] exp_d;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = sel;
        bus.auto_mode = am;
        bus.sync      = sy;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        t         = am ? m_ptr : int'(sel);
        exp_ready = !m_full[t] || ordy[t];
        if (m_known) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("cur_sel", 32'(bus.cur_sel), 32'(t));
        end
        acc = v && exp_ready && !r;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = 4'h0;
            end
            m_ptr   = 0;
            m_fd    = 1'b0;
            m_known = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && k == t) begin
                    m_full[k] = 1'b1;
                    m_data[k] = d;
                end else if (m_full[k] && ordy[k]) begin
                    m_full[k] = 1'b0;
                end
            end
            m_fd = acc && am && (t == 3);
            if (acc && am) m_ptr = sy ? 1 : (m_ptr + 1) % 4;
            else if (sy)   m_ptr = 0;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            for (int k = 0; k < 4; k++) begin
                exp_v[k]         = m_full[k];
                exp_d[k*4 +: 4]  = m_data[k];
            end
            chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
            chk("out_data", 32'(bus.out_data), 32'(exp_d));
            chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.auto_mode = 1'b0;
        bus.sync      = 1'b0;
        bus.out_ready = '0;
        rst           = 1'b1;

        // Reset two cycles, then direct mode A->lane 2, 5->lane 0
        step(0, 4'h0, 2'd0, 0, 0, 4'hF, 1);
        step(0, 4'h0, 2'd0, 0, 0, 4'hF, 1);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_frame", 32'(bus.frame_done), 32'h0);
        step(1, 4'hA, 2'd2, 0, 0, 4'hF, 0);
        chk("direct_lane2", 32'(bus.out_data[11:8]), 32'hA);
        step(1, 4'h5, 2'd0, 0, 0, 4'hF, 0);
        chk("direct_lane0", 32'(bus.out_data[3:0]), 32'h5);
        step(0, 4'h0, 2'd0, 0, 0, 4'hF, 0);

        // Round-robin beats 1..5, frame_done after beat 4
        for (int i = 1; i <= 5; i++) step(1, 4'(i), 2'd0, 1, 0, 4'hF, 0);
        step(0, 4'h0, 2'd0, 1, 0, 4'hF, 0);

        // Back-pressure on lane 1: restart pointer, then 7,8,9,10,11 and a held 12
        step(0, 4'h0, 2'd0, 1, 1, 4'hF, 0);
        step(1, 4'h7, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'h8, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'h9, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'hA, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'hB, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'hC, 2'd0, 1, 0, 4'b1101, 0);
        chk("bp_stall", 32'(bus.in_ready), 32'h0);
        step(1, 4'hC, 2'd0, 1, 0, 4'b1101, 0);
        step(1, 4'hC, 2'd0, 1, 0, 4'b1111, 0);
        chk("bp_lane1", 32'(bus.out_data[7:4]), 32'hC);
        step(0, 4'h0, 2'd0, 1, 0, 4'hF, 0);

        // Simultaneous write and drain on lane 0
        step(1, 4'h3, 2'd0, 0, 0, 4'b0000, 0);
        step(1, 4'h6, 2'd0, 0, 0, 4'b0001, 0);
        chk("wd_lane0", 32'(bus.out_data[3:0]), 32'h6);
        step(0, 4'h0, 2'd0, 0, 0, 4'hF, 0);

        // sync with accept at ptr=2, then standalone sync at ptr=3
        step(0, 4'h0, 2'd0, 1, 1, 4'hF, 0);
        step(1, 4'h1, 2'd0, 1, 0, 4'hF, 0);
        step(1, 4'h2, 2'd0, 1, 0, 4'hF, 0);
        step(1, 4'hB, 2'd0, 1, 1, 4'hF, 0);
        chk("sync_lane2", 32'(bus.out_data[11:8]), 32'hB);
        chk("sync_ptr1", 32'(bus.cur_sel), 32'h1);
        step(1, 4'hD, 2'd0, 1, 0, 4'hF, 0);
        step(1, 4'hE, 2'd0, 1, 0, 4'hF, 0);
        step(0, 4'h0, 2'd0, 1, 1, 4'hF, 0);
        chk("sync_ptr0", 32'(bus.cur_sel), 32'h0);

        // Mid-stream reset with lanes full
        for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 2'(i), 0, 0, 4'h0, 0);
        step(0, 4'h0, 2'd0, 0, 0, 4'h0, 1);
        chk("midreset_valid", 32'(bus.out_valid), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 4'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_lane.md
# demux4_lane

Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the distributing counterpart of the team's 4-to-1 select circuits: it takes one input stream and steers each beat to one of four output lanes. The target lane comes from an explicit 2-bit select or from an internal round-robin pointer. Each lane has a one-entry holding register, so a stalled lane does not lose data.

## Interface

- WIDTH, 1, data bits per beat and per lane

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  beat to distribute
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  beat is accepted this cycle when in_valid and in_ready are both 1
- in_sel  input  2  target lane in direct mode; ignored in auto mode
- auto_mode  input  1  1 = round-robin pointer selects the lane; 0 = in_sel selects it
- sync  input  1  clears the round-robin pointer to 0
- out_data  output  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  4  lane k holding register is full
- out_ready  input  4  lane k consumer takes its data
- cur_sel  output  2  lane the next beat targets (pointer in auto mode, in_sel in direct mode)
- frame_done  output  1  one-cycle pulse after an auto-mode beat is accepted into lane 3

## Operation

- Target lane: t = auto_mode ? ptr : in_sel.
- in_ready = !out_valid[t] || out_ready[t]. This is combinational and does not depend on in_valid.
- Accept occurs when in_valid && in_ready. On accept:
  - lane t data register loads in_data;
  - out_valid[t] is set to 1.
- Drain: lane k clears out_valid[k] when out_valid[k] && out_ready[k] and lane k is not written in the same cycle.
- Write and drain on the same lane in the same cycle:
  - new data is loaded;
  - out_valid stays 1 (full throughput).
- Lanes other than t are unaffected by an accept. They drain independently.
- Round-robin pointer ptr (2 bits):
  - advances by 1 only on an accepted beat in auto mode, wrapping 3 -> 0;
  - holds in direct mode.
- sync has priority over advance:
  - sync=1 with no auto-mode accept: ptr becomes 0 next cycle;
  - sync=1 with an auto-mode accept in the same cycle: the beat goes to the current ptr, then ptr becomes 1.
- Changing auto_mode mid-stream does not modify ptr.
- frame_done is registered: 1 for exactly the cycle after an auto-mode accept into lane 3, otherwise 0.
- out_data of an empty lane keeps its last value. Consumers must qualify it with out_valid.

## Timing

- Reset (rst=1 at an edge) sets:
  - out_valid = 4'b0000;
  - out_data = all zeros;
  - ptr = 0;
  - frame_done = 0.
- While rst is held, in_ready is still driven as the combinational value, but no beat is accepted or stored.
- Reset mid-operation discards all held lane data. No partial frame state survives reset.
- Latency: a beat accepted at edge N has out_valid[t]=1 and out_data lane t valid immediately after edge N (one register stage).
- Throughput: one beat per cycle when the target lane is empty or draining.
- Back-pressure example: lane t full and out_ready[t]=0 gives in_ready=0. This holds even if other lanes are empty; there is no skipping ahead in auto mode.
- cur_sel reflects ptr after the edge, so cur_sel equals the lane for the next accept.
- Consumers may hold out_ready high permanently.
- The block does not require in_valid to stay asserted while in_ready=0. If it does stay asserted, in_data and in_sel must be held.

## Test plan

- Reset and direct mode:
  - stimulus: assert rst 2 cycles; then auto_mode=0, out_ready=4'b1111, send 4'hA/sel=2, 4'h5/sel=0 (WIDTH=4);
  - response: after reset out_valid=0 and frame_done=0; lane 2 shows A one cycle after its accept, lane 0 shows 5 one cycle after its accept, other lanes stay invalid.
- Round-robin with frame pulse:
  - stimulus: auto_mode=1, in_valid continuous, beats 1,2,3,4,5, all out_ready=1;
  - response: lanes 0,1,2,3,0 receive 1,2,3,4,5; frame_done is high exactly one cycle, right after beat 4; cur_sel sequence is 0,1,2,3,0,1.
- Back-pressure:
  - stimulus: out_ready[1]=0, auto mode; send beats 7,8,9;
  - response: 7 goes to lane 0, 8 to lane 1; beat 9 targets lane 2 and is accepted; after wrap to lane 1 with lane 1 still full, in_ready=0 and the beat is held; raising out_ready[1] accepts it in that same cycle with out_valid[1] staying 1.
- Simultaneous write and drain:
  - stimulus: lane 0 full with 3, out_ready[0]=1, new beat 6 to lane 0 in the same cycle;
  - response: in_ready=1; out_data lane 0 = 6 the next cycle; out_valid[0] never drops.
- sync behaviour:
  - stimulus: ptr=2; assert sync with an accept of beat B; then sync alone when ptr=3;
  - response: B lands in lane 2 and ptr becomes 1; the standalone sync gives ptr=0; reset mid-stream clears all out_valid on the next cycle.
